// File: rtl/cellrv32_package.sv
// Shared TRNG definitions: controller state encoding and output byte width.
package cellrv32_package;

  localparam int TRNG_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    STARTUP,
    WARMUP,
    RUN,
    ERROR
  } trng_state_t;

endpackage

// File: rtl/cell_trng_debias.sv
// Von Neumann de-biaser: pairs consecutive samples and packs the emitted bits
// MSB-first into bytes, offering each completed byte for exactly one cycle.
module cell_trng_debias
  import cellrv32_package::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   s,
  output logic                   byte_vld,
  output logic [TRNG_BYTE_W-1:0] byte_data
);

  localparam int CNT_W = $clog2(TRNG_BYTE_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRNG_BYTE_W - 1);

  logic                   phase;
  logic                   first;
  logic [TRNG_BYTE_W-1:0] acc;
  logic [CNT_W-1:0]       cnt;
  logic                   bit_vld;

  // A differing pair (first, s) always emits the second sample.
  assign bit_vld   = run & phase & (first ^ s);
  assign byte_vld  = bit_vld & (cnt == CNT_LAST);
  assign byte_data = {acc[TRNG_BYTE_W-2:0], s};

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      phase <= 1'b0;
      first <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      phase <= ~phase;
      if (!phase) first <= s;
      if (bit_vld) begin
        acc <= {acc[TRNG_BYTE_W-2:0], s};
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cell_trng_ctrl.sv
// cellTRNG chain controller: startup/warmup sequencing, raw-bit synchronizer,
// repetition health test and the byte output handshake.
module cell_trng_ctrl
  import cellrv32_package::*;
#(
  parameter int NUM_CELLS  = 3,
  parameter int WARMUP_CYC = 512,
  parameter int REP_LIMIT  = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  output logic                   cell_en_o,
  output logic                   cell_sel_o,
  input  logic                   cell_done_i,
  input  logic [NUM_CELLS-1:0]   cell_data_i,
  output logic [TRNG_BYTE_W-1:0] rnd_data_o,
  output logic                   rnd_valid_o,
  input  logic                   rnd_ready_i,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int WARM_W = $clog2(WARMUP_CYC) + 1;
  localparam int REP_W  = $clog2(REP_LIMIT) + 1;

  trng_state_t state, state_next;

  logic                   sync_p0, sync_p1, s_prev;
  logic [WARM_W-1:0]      warm_cnt;
  logic [REP_W-1:0]       rep_cnt, rep_next;
  logic                   trip, abort, run;
  logic                   cell_en_d, busy_d, err_d;
  logic                   byte_vld;
  logic [TRNG_BYTE_W-1:0] byte_data;

  // Stage p0/p1: two-flop synchronizer of the XOR-combined cell outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      s_prev  <= 1'b0;
    end else begin
      sync_p0 <= ^cell_data_i;
      sync_p1 <= sync_p0;
      s_prev  <= sync_p1;
    end
  end

  // On the first RUN cycle rep_cnt is 0, so the first sample always counts as 1.
  always_comb begin
    rep_next = rep_cnt;
    if (sync_p1 != s_prev)                 rep_next = REP_W'(1);
    else if (rep_cnt < REP_W'(REP_LIMIT))  rep_next = rep_cnt + 1'b1;
  end

  assign trip = (state == RUN) && (rep_next == REP_W'(REP_LIMIT));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cell_en_o   <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_next;
      cell_en_o   <= cell_en_d;
      busy_o      <= busy_d;
      err_o       <= err_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en_i) state_next = STARTUP;
      STARTUP: if (cell_done_i) state_next = WARMUP;
      WARMUP:  if (warm_cnt == WARM_W'(WARMUP_CYC - 1)) state_next = RUN;
      RUN:     if (trip) state_next = ERROR;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
    if (state != IDLE && !en_i) state_next = IDLE;
  end

  always_comb begin
    cell_en_d = (state_next == STARTUP) || (state_next == WARMUP) || (state_next == RUN);
    busy_d    = (state_next != IDLE);
    err_d     = (state_next == ERROR);
  end

  // Leaving RUN (or sitting outside it) flushes the sampling datapath.
  assign abort = (state_next == IDLE) || (state_next == ERROR);
  assign run   = (state == RUN) && (state_next == RUN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      warm_cnt <= '0;
    end else if (state == STARTUP && cell_done_i) begin
      warm_cnt <= '0;
    end else if (state == WARMUP && warm_cnt < WARM_W'(WARMUP_CYC - 1)) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !run) rep_cnt <= '0;
    else               rep_cnt <= rep_next;
  end

  cell_trng_debias u_debias (
    .clk       (clk_i),
    .rst       (rst_i),
    .run       (run),
    .s         (sync_p1),
    .byte_vld  (byte_vld),
    .byte_data (byte_data)
  );

  // A byte offered while the held byte is not being taken is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rnd_data_o  <= '0;
      rnd_valid_o <= 1'b0;
      cell_sel_o  <= 1'b0;
    end else begin
      if (rnd_valid_o && rnd_ready_i) cell_sel_o <= ~cell_sel_o;
      if (abort) begin
        rnd_data_o  <= '0;
        rnd_valid_o <= 1'b0;
      end else if (byte_vld && (!rnd_valid_o || rnd_ready_i)) begin
        rnd_data_o  <= byte_data;
        rnd_valid_o <= 1'b1;
      end else if (rnd_valid_o && rnd_ready_i) begin
        rnd_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cell_trng_ctrl.sv
// Bench for cell_trng_ctrl: queue-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_cell_trng_ctrl;

  localparam int NC = 1;
  localparam int WC = 4;
  localparam int RL = 8;

  localparam int M_IDLE  = 0;
  localparam int M_START = 1;
  localparam int M_WARM  = 2;
  localparam int M_RUN   = 3;
  localparam int M_ERR   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          done = 1'b0;
  logic          ready = 1'b0;
  logic [NC-1:0] data = '0;
  logic          cell_en, cell_sel, rnd_valid, busy, err;
  logic [7:0]    rnd_data;

  cell_trng_ctrl #(.NUM_CELLS(NC), .WARMUP_CYC(WC), .REP_LIMIT(RL)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .cell_en_o   (cell_en),
    .cell_sel_o  (cell_sel),
    .cell_done_i (done),
    .cell_data_i (data),
    .rnd_data_o  (rnd_data),
    .rnd_valid_o (rnd_valid),
    .rnd_ready_i (ready),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int   m_mode = M_IDLE;
  int   m_warm = 0;
  int   m_runlen = 0;
  bit   m_last = 1'b0;
  bit   m_live = 1'b0;
  bit   sq[$];
  bit   smp[$];
  bit   bits[$];
  bit [7:0] e_data = '0;
  bit   e_valid = 0, e_sel = 0, e_en = 0, e_busy = 0, e_err = 0;
  int   warm_cycles = 0;
  logic [7:0] got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit s, xfer, offer, old_valid;
    bit [7:0] obyte;
    if (rst) begin
      m_mode = M_IDLE; m_warm = 0; m_runlen = 0; m_last = 0;
      sq = {1'b0, 1'b0};
      smp.delete(); bits.delete();
      e_data = '0; e_valid = 0; e_sel = 0;
      m_live = 1'b1;
    end else begin
      s = sq.pop_front();
      sq.push_back(^data);
      old_valid = e_valid;
      xfer = e_valid && ready;
      if (xfer) e_sel = !e_sel;
      offer = 0;
      obyte = '0;
      if (m_mode != M_IDLE && !en) begin
        m_mode = M_IDLE;
      end else begin
        case (m_mode)
          M_IDLE:  if (en) m_mode = M_START;
          M_START: if (done) begin m_mode = M_WARM; m_warm = WC; end
          M_WARM: begin
            m_warm--;
            if (m_warm == 0) m_mode = M_RUN;
          end
          M_RUN: begin
            smp.push_back(s);
            if (smp.size() == 2) begin
              if (smp[0] != smp[1]) bits.push_back(s);
              smp.delete();
            end
            if (bits.size() == 8) begin
              offer = 1;
              foreach (bits[i]) obyte = {obyte[6:0], bits[i]};
              bits.delete();
            end
            if (m_runlen == 0 || s != m_last) m_runlen = 1;
            else m_runlen++;
            m_last = s;
            if (m_runlen == RL) m_mode = M_ERR;
          end
          default: ;
        endcase
      end
      if (m_mode != M_RUN) begin
        smp.delete(); bits.delete(); m_runlen = 0;
      end
      if (m_mode == M_IDLE || m_mode == M_ERR) begin
        e_data = '0; e_valid = 0;
      end else if (offer && (!old_valid || ready)) begin
        e_data = obyte; e_valid = 1;
      end else if (xfer) begin
        e_valid = 0;
      end
      if (m_mode == M_WARM) warm_cycles++;
    end
    e_en   = (m_mode == M_START) || (m_mode == M_WARM) || (m_mode == M_RUN);
    e_busy = (m_mode != M_IDLE);
    e_err  = (m_mode == M_ERR);
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("rnd_data", rnd_data, e_data);
      chk("rnd_valid", rnd_valid, e_valid);
      chk("cell_sel", cell_sel, e_sel);
      chk("cell_en", cell_en, e_en);
      chk("busy", busy, e_busy);
      chk("err", err, e_err);
      if (rnd_valid && ready) got.push_back(rnd_data);
    end
  end

  task automatic push(input bit b);
    data = '0;
    data[0] = b;
    @(posedge clk);
    #1;
  endtask

  // Returns when the next driven bit will be the first sample of RUN.
  task automatic align();
    int k;
    for (k = 0; k < 40; k++) begin
      if (m_mode == M_WARM && m_warm == 2) break;
      push(1'b0);
    end
    if (k == 40) begin
      n_chk++; n_fail++;
      $display("FAIL align: warmup not reached within %0d cycles", k);
    end
  endtask

  task automatic pairs(input bit a, input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      push(a);
      push(b);
    end
  endtask

  task automatic send_aa();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin pairs(0, 1, 1); pairs(0, 0, 1); end
      else            begin pairs(1, 0, 1); pairs(1, 1, 1); end
    end
  endtask

  initial begin
    bit lastb, b;
    int runc;
    rst = 1'b1; en = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_data", rnd_data, 8'h00);
    chk("rst_valid", rnd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_cell_en", cell_en, 0);
    chk("rst_sel", cell_sel, 0);
    rst = 1'b0;
    push(0);
    chk("cell_en_after_rst", cell_en, 1);
    repeat (9) push(0);
    warm_cycles = 0;
    done = 1'b1;
    align();

    // Backpressure: 0xFF is held, the following 0x00 is dropped
    ready = 1'b0;
    pairs(0, 1, 8);
    pairs(1, 0, 8);
    pairs(0, 0, 1); pairs(1, 1, 1);
    chk("warmup_len", warm_cycles, 4);
    chk("bp_valid", rnd_valid, 1);
    chk("bp_hold_ff", rnd_data, 8'hFF);
    chk("bp_sel_before", cell_sel, 0);
    ready = 1'b1;
    push(0);
    ready = 1'b0;
    chk("bp_valid_after", rnd_valid, 0);
    chk("bp_sel_after", cell_sel, 1);
    push(0);

    ready = 1'b1;
    got.delete();
    pairs(1, 0, 8);
    pairs(0, 0, 1); pairs(1, 1, 1);
    chk("n_bytes_00", got.size(), 1);
    chk("byte_00", got.size() > 0 ? got[0] : 8'hxx, 8'h00);

    got.delete();
    send_aa();
    pairs(0, 0, 1); pairs(1, 1, 1);
    chk("n_bytes_aa", got.size(), 1);
    chk("byte_aa", got.size() > 0 ? got[0] : 8'hxx, 8'hAA);

    // Random run-limited stream with random backpressure
    lastb = 1'b1; runc = 2;
    for (int i = 0; i < 400; i++) begin
      b = 1'($urandom_range(0, 1));
      if (b == lastb && runc >= 5) b = ~lastb;
      runc = (b == lastb) ? runc + 1 : 1;
      lastb = b;
      ready = 1'($urandom_range(0, 1));
      push(b);
    end

    // Health test trip
    ready = 1'b1;
    repeat (12) push(0);
    chk("health_err", err, 1);
    chk("health_cell_en", cell_en, 0);
    chk("health_valid", rnd_valid, 0);
    en = 1'b0;
    push(0);
    chk("health_clear_err", err, 0);
    chk("health_idle", busy, 0);
    en = 1'b1;
    push(0);
    chk("restart_busy", busy, 1);
    chk("restart_cell_en", cell_en, 1);

    // Abort mid-byte, then restart with a clean accumulator
    align();
    pairs(0, 1, 5);
    pairs(0, 0, 1);
    en = 1'b0;
    push(0);
    chk("abort_idle", busy, 0);
    chk("abort_valid", rnd_valid, 0);
    en = 1'b1;
    push(0);
    align();
    got.delete();
    send_aa();
    pairs(0, 0, 1); pairs(1, 1, 1);
    chk("n_bytes_restart", got.size(), 1);
    chk("byte_restart_aa", got.size() > 0 ? got[0] : 8'hxx, 8'hAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cell_trng_ctrl.md
Name: cell_trng_ctrl

Overview:
- Controller that sequences a chain of cellTRNG entropy cells.
- Drives the chain enable and the short/long delay select, then waits for the enable chain to propagate through all cells.
- Combines the cell outputs into a raw bit stream, de-biases it (von Neumann), runs a repetition health test, and delivers bytes over a valid/ready handshake to the TRNG bus interface.

Parameters:
- NUM_CELLS, 3, number of entropy cells; width of cell_data_i (>=1).
- WARMUP_CYC, 512, RUN-preceding cycles whose samples are discarded (>=1).
- REP_LIMIT, 64, consecutive identical raw bits that trip the health error (>=2).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- en_i  in  1  TRNG enable from the control register
- cell_en_o  out  1  enable_i of the first cell in the chain
- cell_sel_o  out  1  select_i broadcast to all cells (0 = short chain, 1 = long chain)
- cell_done_i  in  1  enable_o of the last cell (chain fully enabled)
- cell_data_i  in  NUM_CELLS  data_o of every cell (asynchronous)
- rnd_data_o  out  8  random byte
- rnd_valid_o  out  1  rnd_data_o is valid
- rnd_ready_i  in  1  consumer accepts the byte
- busy_o  out  1  state is not IDLE
- err_o  out  1  health test failed (sticky until en_i=0)

Behaviour:
- Reset (rst_i=1 at a clk_i edge): highest priority. State=IDLE. All outputs and internal registers go to 0.
- Raw path:
  - raw = XOR-reduction of cell_data_i.
  - raw passes through a 2-FF synchronizer. Its output s is registered and always running.
- FSM states: IDLE, STARTUP, WARMUP, RUN, ERROR.
  - IDLE: cell_en_o=0. en_i=1 -> STARTUP.
  - STARTUP: cell_en_o=1. cell_done_i=1 -> WARMUP and clear the warmup counter.
  - WARMUP: cell_en_o=1. The counter increments each cycle. When the counter reaches WARMUP_CYC-1 -> RUN. All samples are discarded.
  - RUN: cell_en_o=1, sampling active.
  - ERROR: cell_en_o=0, err_o=1, rnd_valid_o=0.
  - In every non-IDLE state, en_i=0 -> IDLE next cycle. This clears the accumulator, the output register, rnd_valid_o, err_o, the pair phase and the repetition counter. cell_sel_o keeps its value.
  - busy_o = (state != IDLE). All outputs are registered.
- Debias (RUN only):
  - A pair-phase bit toggles every RUN cycle, starting at phase 0 on the first RUN cycle.
  - Phase 0 stores s as first. Phase 1 compares first with s:
    - (0,1) emits bit 1.
    - (1,0) emits bit 0.
    - equal pairs emit nothing.
- Accumulator:
  - 8-bit shift register plus a 3-bit count. Each emitted bit shifts in at the LSB: acc <= {acc[6:0], b}.
  - When the count wraps from 7 to 0 (8th bit), the complete byte {acc[6:0], b} is offered to the output register.
- Output register and handshake:
  - The offered byte loads if rnd_valid_o=0, or if rnd_valid_o=1 and rnd_ready_i=1 in the same cycle (back-to-back).
  - After loading, rnd_data_o holds the byte and rnd_valid_o=1 from the next cycle.
  - If the offer cannot load, the byte is dropped and the accumulator continues.
  - While rnd_valid_o=1 and rnd_ready_i=0, rnd_data_o is stable.
  - Transfer occurs when rnd_valid_o and rnd_ready_i are both 1. rnd_valid_o drops next cycle unless a new byte loads in that cycle.
- Select scheduling: cell_sel_o toggles on every completed transfer (alternates short/long chain per byte). Reset value 0.
- Health test (RUN only):
  - The repetition counter resets to 1 whenever s differs from the previous s, else increments.
  - Reaching REP_LIMIT -> ERROR next cycle. The output register and accumulator are cleared.
- Counter widths: $clog2 of their limits + 1. Counters saturate and never wrap.

Decomposition:
- Shared package cellrv32_package gets:
  - trng_state_t enum (IDLE, STARTUP, WARMUP, RUN, ERROR).
  - TRNG_BYTE_W = 8.
- One natural sub-module: cell_trng_debias (pair phase, von Neumann extraction, 8-bit accumulator). Interface: s and run in; bit-valid and byte out.
- FSM, health test, handshake and select logic stay in the top module.

Test Plan (NUM_CELLS=1, WARMUP_CYC=4, REP_LIMIT=8; the bench stub drives cell_data_i and cell_done_i, aligned via the 2-cycle synchronizer):
- Reset: rst_i=1 for 2 cycles with en_i=1 -> all outputs 0, busy_o=0; cell_en_o=1 one cycle after rst_i falls.
- Startup: en_i=1, cell_done_i asserted 10 cycles later -> WARMUP lasts exactly 4 cycles, then RUN; no rnd_valid_o before the first full byte.
- Debias:
  - Pairs (0,1)x8 in RUN -> rnd_data_o=0xFF.
  - Pairs (1,0)x8 -> 0x00.
  - Alternating (0,1),(1,0) with (0,0)/(1,1) pairs interleaved -> 0xAA.
  - Pair runs are kept under 8 identical bits.
- Backpressure: rnd_ready_i=0 while two bytes (0xFF then 0x00) complete -> rnd_data_o holds 0xFF and 0x00 is dropped. ready=1 for one cycle -> valid=0 next cycle and cell_sel_o toggles 0 to 1.
- Health: s constant 0 for 8 cycles in RUN -> err_o=1, cell_en_o=0, rnd_valid_o=0. en_i 0 then 1 -> err_o clears and STARTUP is re-entered.
- Abort: en_i=0 mid-byte (5 bits accumulated) -> IDLE next cycle. After restart, the first byte contains no stale bits.
